// File: rtl/shift_reg_pkg.sv
// Shared types and defaults for the serial shift-register controller.
package shift_reg_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_reg_ctrl_xfer_counter.sv
// Bit counter for one transfer: cleared on accept, advanced every SHIFT cycle,
// flags the terminal count on which the FSM leaves SHIFT.
module xfer_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TERM  = 11
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, otherwise hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CNT_W'(TERM));

endmodule

// File: rtl/shift_reg_ctrl.sv
// Serializes a parallel word MSB-first into an external DEPTH-stage shift
// register and reassembles the word coming back on sr_out.
module shift_reg_ctrl
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             sr_in,
    input  logic             sr_out,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic [15:0]      xfer_cnt
);

    localparam int unsigned CNT_W = cnt_width(WIDTH + DEPTH);
    localparam int unsigned TERM  = WIDTH + DEPTH - 1;

    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   tx_shift_q;
    logic [WIDTH-1:0]   tx_shift_d;
    logic [WIDTH-1:0]   rx_shift_q;
    logic [WIDTH-1:0]   rx_shift_d;
    logic [15:0]        xfer_cnt_q;
    logic [15:0]        xfer_cnt_d;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc;
    logic               accept;
    logic               handshake;

    assign accept    = (state_q == IDLE) && tx_valid;
    assign handshake = (state_q == DONE) && rx_ready;

    xfer_counter #(
        .CNT_W (CNT_W),
        .TERM  (TERM)
    ) u_xfer_counter (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (accept),
        .en_i   (state_q == SHIFT),
        .cnt_o  (cnt),
        .tc_o   (cnt_tc)
    );

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, leave SHIFT on terminal count, release DONE on rx_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tx_valid) state_d = SHIFT;
            SHIFT:   if (cnt_tc)   state_d = DONE;
            DONE:    if (rx_ready) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and registered datapath only (no path from tx_data).
    always_comb begin
        tx_ready = 1'b0;
        busy     = 1'b1;
        rx_valid = 1'b0;
        sr_in    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            SHIFT: begin
                // Past the last data bit, zeros flush the external register.
                sr_in = (cnt < CNT_W'(WIDTH)) ? tx_shift_q[WIDTH-1] : 1'b0;
            end
            DONE: begin
                rx_valid = 1'b1;
            end
            default: begin
                tx_ready = 1'b0;
                busy     = 1'b1;
            end
        endcase
    end

    // Datapath next state: load on accept, shift while in SHIFT, count handshakes.
    always_comb begin
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        xfer_cnt_d = xfer_cnt_q;
        if (accept) begin
            tx_shift_d = tx_data;
            rx_shift_d = '0;
        end else if (state_q == SHIFT) begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            // The first driven bit reaches sr_out DEPTH cycles later.
            if (cnt >= CNT_W'(DEPTH)) begin
                rx_shift_d = {rx_shift_q[WIDTH-2:0], sr_out};
            end
        end
        if (handshake) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the shift words and counter are plain flops, so all of them are reset.
        if (!resetn) begin
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            xfer_cnt_q <= '0;
        end else begin
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign rx_data  = rx_shift_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench for shift_reg_ctrl with an external 4-flop delay line.
module tb_shift_reg_ctrl;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] tx_data = '0;
    logic         sr_in;
    logic         sr_out;
    logic         rx_valid;
    logic         rx_ready = 1'b1;
    logic [W-1:0] rx_data;
    logic         busy;
    logic [15:0]  xfer_cnt;

    logic [D-1:0] dl_q;
    logic         flip = 1'b0;

    int           checks = 0;
    int           errors = 0;
    int           edge_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [15:0]  exp_xfer = '0;
    int           acc;
    int           rel;
    logic [W-1:0] pat;

    shift_reg_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .sr_in    (sr_in),
        .sr_out   (sr_out),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // External delay line; flip inverts the last stage for corruption tests.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) dl_q <= '0;
        else         dl_q <= {dl_q[D-2:0], sr_in};
    end
    assign sr_out = dl_q[D-1] ^ flip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: pops an expected word on every rx handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: unexpected word 0x%0h, no word expected", rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(mon_exp));
                end
            end
        end
    end

    // Offer a word from a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] e, input bit keep, output int acc_edge);
        acc_edge = -1;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (tx_ready === 1'b1) begin
                acc_edge = edge_cnt + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc_edge < 0) begin
            checks++;
            errors++;
            $display("FAIL accept timeout: tx_ready never high for word 0x%0h", d);
            tx_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
        check("busy after accept", 32'(busy), 32'd1);
    endtask

    // Wait for rx_valid, check latency, optionally hold off rx_ready, then handshake.
    task automatic finish_rx(input int acc_edge, input int hold, input logic [W-1:0] hold_exp);
        int seen = -1;
        for (int i = 0; i < 60; i++) begin
            if (rx_valid === 1'b1) begin
                seen = edge_cnt;
                break;
            end
            @(negedge clk);
        end
        if (seen < 0) begin
            checks++;
            errors++;
            $display("FAIL rx_valid timeout: never high, expected by edge %0d", acc_edge + W + D + 1);
            rx_ready = 1'b1;
            return;
        end
        // rx_valid is first seen high when sampling at edge acc+W+D+1.
        check("rx_valid latency", 32'(seen + 1 - acc_edge), 32'(W + D + 1));
        for (int h = 0; h < hold; h++) begin
            check("held rx_valid", 32'(rx_valid), 32'd1);
            check("held rx_data", 32'(rx_data), 32'(hold_exp));
            check("tx_ready in DONE", 32'(tx_ready), 32'd0);
            @(negedge clk);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        exp_xfer = exp_xfer + 16'd1;
        check("tx_ready after handshake", 32'(tx_ready), 32'd1);
        check("busy after handshake", 32'(busy), 32'd0);
        check("rx_valid after handshake", 32'(rx_valid), 32'd0);
        check("xfer_cnt", 32'(xfer_cnt), 32'(exp_xfer));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        check("reset tx_ready", 32'(tx_ready), 32'd1);
        check("reset sr_in", 32'(sr_in), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset xfer_cnt", 32'(xfer_cnt), 32'd0);
        resetn = 1'b1;

        // Mid-transfer reset at cnt=6, then 8'h81 on the first edge after release.
        send(8'h77, 8'h77, 1'b0, acc);
        repeat (6) @(negedge clk);
        check("sr_in at cnt 6", 32'(sr_in), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("abort sr_in", 32'(sr_in), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rx_valid", 32'(rx_valid), 32'd0);
        check("abort tx_ready", 32'(tx_ready), 32'd1);
        check("abort rx_data", 32'(rx_data), 32'd0);
        check("abort xfer_cnt", 32'(xfer_cnt), 32'(exp_xfer));
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        rel = edge_cnt;
        send(8'h81, 8'h81, 1'b0, acc);
        check("accept on first edge after reset", 32'(acc), 32'(rel + 1));
        finish_rx(acc, 0, '0);

        // Loopback of 8'hA5 with the serial stream checked bit by bit.
        pat = 8'hA5;
        send(pat, pat, 1'b0, acc);
        for (int k = 0; k < W + D; k++) begin
            if (k < W) check("sr_in data bit", 32'(sr_in), 32'(pat[W-1-k]));
            else       check("sr_in flush", 32'(sr_in), 32'd0);
            check("rx_valid low in SHIFT", 32'(rx_valid), 32'd0);
            @(negedge clk);
        end
        finish_rx(acc, 0, '0);

        // Backpressure: rx_ready low for 5 cycles in DONE.
        rx_ready = 1'b0;
        send(8'h3C, 8'h3C, 1'b0, acc);
        finish_rx(acc, 5, 8'h3C);

        // Back-to-back: tx_valid held high across two words.
        send(8'h01, 8'h01, 1'b1, acc);
        rel = acc;
        send(8'hFF, 8'hFF, 1'b0, acc);
        check("back-to-back spacing", 32'(acc - rel), 32'(W + D + 2));
        exp_xfer = exp_xfer + 16'd1;
        finish_rx(acc, 0, '0);

        // Corruption: last delay stage inverted during cnt=6 hits bit 5.
        send(8'h5A, 8'h5A ^ 8'h20, 1'b0, acc);
        repeat (6) @(negedge clk);
        flip = 1'b1;
        @(negedge clk);
        flip = 1'b0;
        finish_rx(acc, 0, '0);

        // Wrap: counter preset to 16'hFFFF, one transfer wraps it to zero.
        force dut.xfer_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.xfer_cnt_q;
        @(negedge clk);
        exp_xfer = 16'hFFFF;
        check("xfer_cnt preset", 32'(xfer_cnt), 32'(exp_xfer));
        send(8'h96, 8'h96, 1'b0, acc);
        finish_rx(acc, 0, '0);
        check("xfer_cnt wrapped", 32'(xfer_cnt), 32'h0000);

        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
